// File: rtl/osd_pkg.sv
// Shared types and helpers for the OSD top-L candidate selector.
// Provides the FSM state encoding, the derived score width and the
// list entry record layout {valid, score, cand, idx} (MSB first).
package osd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // Width of the valid flag heading each list entry record
   localparam int unsigned ENTRY_VALID_W = 1;

   // Signed width that holds a sum of K sign-extended U_WIDTH terms without overflow
   function automatic int unsigned score_width(input int unsigned k, input int unsigned u_width);
      return u_width + $clog2(k + 1);
   endfunction

   // Total width of one list entry record {valid, score, cand, idx}
   function automatic int unsigned entry_width(input int unsigned k, input int unsigned sw,
                                               input int unsigned iw);
      return ENTRY_VALID_W + sw + k + iw;
   endfunction

endpackage

// File: rtl/osd_topl_selector_if.sv
// Candidate stream and result stream of the top-L selector.
//   cand_valid/cand_ready/cand_data/cand_last : incoming test-error patterns
//   res_valid/res_ready/res_cand/res_score/res_idx/res_rank/res_last : sorted list readout
// master = pattern generator + back end side, slave = selector side.
interface osd_topl_selector_if #(
   parameter int unsigned K         = 32,
   parameter int unsigned U_WIDTH   = 13,
   parameter int unsigned L         = 4,
   parameter int unsigned IDX_WIDTH = 10
);
   import osd_pkg::*;

   localparam int unsigned SCORE_WIDTH = score_width(K, U_WIDTH);
   localparam int unsigned RANK_WIDTH  = $clog2(L) + 1;

   logic                          cand_valid;
   logic                          cand_ready;
   logic [K-1:0]                  cand_data;
   logic                          cand_last;

   logic                          res_valid;
   logic                          res_ready;
   logic [K-1:0]                  res_cand;
   logic signed [SCORE_WIDTH-1:0] res_score;
   logic [IDX_WIDTH-1:0]          res_idx;
   logic [RANK_WIDTH-1:0]         res_rank;
   logic                          res_last;

   modport master (
      output cand_valid, cand_data, cand_last, res_ready,
      input  cand_ready, res_valid, res_cand, res_score, res_idx, res_rank, res_last
   );

   modport slave (
      input  cand_valid, cand_data, cand_last, res_ready,
      output cand_ready, res_valid, res_cand, res_score, res_idx, res_rank, res_last
   );

endinterface

// File: rtl/osd_cand_scorer.sv
// Combinational candidate scorer: score = sum_j (1 - 2*a_j) * u_j.
//   u_flat : K signed u_j values, u_j at [j*U_WIDTH +: U_WIDTH]
//   a      : test-error pattern, bit j = a_j
//   score  : signed SCORE_WIDTH result
module osd_cand_scorer
   import osd_pkg::*;
#(
   parameter int unsigned K           = 32,
   parameter int unsigned U_WIDTH     = 13,
   parameter int unsigned SCORE_WIDTH = score_width(K, U_WIDTH)
) (
   input  logic [K*U_WIDTH-1:0]          u_flat,
   input  logic [K-1:0]                  a,
   output logic signed [SCORE_WIDTH-1:0] score
);

   // Sign-extend each u_j, then add it (a_j=0) or subtract it (a_j=1)
   always_comb begin : sum
      logic signed [U_WIDTH-1:0]     u_j;
      logic signed [SCORE_WIDTH-1:0] u_ext;
      u_j   = '0;
      u_ext = '0;
      score = '0;
      for (int j = 0; j < K; j++) begin
         u_j   = u_flat[j*U_WIDTH +: U_WIDTH];
         u_ext = SCORE_WIDTH'(u_j);
         score = a[j] ? (score - u_ext) : (score + u_ext);
      end
   end

endmodule

// File: rtl/osd_topl_selector.sv
// Streaming OSD top-L candidate selector.
// Scores each accepted pattern against a registered reliability vector,
// keeps a sorted list of the L best (ties: earlier candidate first) and
// reads the list out, best first, on the result stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a search (IDLE only), u_flat sampled with it
//   abort      : cancel from any state
//   u_flat     : K signed u_j values
//   bus        : candidate and result streams (slave side)
//   busy       : state != IDLE
//   done       : one-cycle pulse after the final result entry is accepted
module osd_topl_selector
   import osd_pkg::*;
#(
   parameter int unsigned K         = 32,
   parameter int unsigned U_WIDTH   = 13,
   parameter int unsigned L         = 4,
   parameter int unsigned IDX_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [K*U_WIDTH-1:0]   u_flat,
   osd_topl_selector_if.slave     bus,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned SW        = score_width(K, U_WIDTH);
   localparam int unsigned RW        = $clog2(L) + 1;
   localparam int unsigned PW        = $clog2(L + 1);
   localparam int unsigned EW        = entry_width(K, SW, IDX_WIDTH);
   localparam int unsigned IDX_LSB   = 0;
   localparam int unsigned CAND_LSB  = IDX_WIDTH;
   localparam int unsigned SCORE_LSB = IDX_WIDTH + K;
   localparam int unsigned VALID_BIT = EW - 1;

   state_e                 state_q, state_d;
   logic [K*U_WIDTH-1:0]   u_q, u_d;
   logic [EW-1:0]          list_q [L];
   logic [EW-1:0]          list_d [L];
   logic [PW-1:0]          fill_q, fill_d;
   logic [IDX_WIDTH-1:0]   idx_cnt_q, idx_cnt_d;

   logic                   stg_v_q, stg_v_d;
   logic signed [SW-1:0]   stg_score_q, stg_score_d;
   logic [K-1:0]           stg_cand_q, stg_cand_d;
   logic [IDX_WIDTH-1:0]   stg_idx_q, stg_idx_d;

   logic [RW-1:0]          rank_q, rank_d;
   logic                   cand_ready_q, cand_ready_d;
   logic                   res_valid_q, res_valid_d;
   logic [K-1:0]           res_cand_q, res_cand_d;
   logic signed [SW-1:0]   res_score_q, res_score_d;
   logic [IDX_WIDTH-1:0]   res_idx_q, res_idx_d;
   logic                   res_last_q, res_last_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic signed [SW-1:0]   beat_score;
   logic [PW-1:0]          ins_pos;
   logic [EW-1:0]          new_entry;
   logic [EW-1:0]          sel_entry;
   logic                   beat;

   osd_cand_scorer #(
      .K           (K),
      .U_WIDTH     (U_WIDTH),
      .SCORE_WIDTH (SW)
   ) u_scorer (
      .u_flat (u_q),
      .a      (bus.cand_data),
      .score  (beat_score)
   );

   assign beat      = cand_ready_q && bus.cand_valid;
   assign new_entry = {1'b1, stg_score_q, stg_cand_q, stg_idx_q};

   // Insert position: valid entries scoring >= the staged one stay ahead of it
   always_comb begin : find_pos
      ins_pos = '0;
      for (int i = 0; i < L; i++) begin
         if (list_q[i][VALID_BIT] && ($signed(list_q[i][SCORE_LSB +: SW]) >= stg_score_q)) begin
            ins_pos = ins_pos + PW'(1);
         end
      end
   end

   // Next-state, list update and registered-output decode
   always_comb begin : next_state
      state_d     = state_q;
      u_d         = u_q;
      list_d      = list_q;
      fill_d      = fill_q;
      idx_cnt_d   = idx_cnt_q;
      stg_v_d     = 1'b0;
      stg_score_d = stg_score_q;
      stg_cand_d  = stg_cand_q;
      stg_idx_d   = stg_idx_q;
      rank_d      = rank_q;
      done_d      = 1'b0;
      sel_entry   = '0;

      // Stage-1 insert; the tail entry falls off when the list is full
      if (stg_v_q && (ins_pos < PW'(L))) begin
         for (int i = 0; i < L; i++) begin
            if (PW'(i) == ins_pos) begin
               list_d[i] = new_entry;
            end else if (PW'(i) > ins_pos) begin
               list_d[i] = list_q[(i == 0) ? 0 : i - 1];
            end
         end
         fill_d = (fill_q == PW'(L)) ? fill_q : fill_q + PW'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               u_d       = u_flat;
               fill_d    = '0;
               idx_cnt_d = '0;
               for (int i = 0; i < L; i++) list_d[i] = '0;
            end
         end
         ST_RUN: begin
            if (beat) begin
               stg_v_d     = 1'b1;
               stg_score_d = beat_score;
               stg_cand_d  = bus.cand_data;
               stg_idx_d   = idx_cnt_q;
               idx_cnt_d   = (idx_cnt_q == '1) ? idx_cnt_q : idx_cnt_q + IDX_WIDTH'(1);
               if (bus.cand_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_OUT;
            rank_d  = '0;
         end
         ST_OUT: begin
            if (bus.res_ready) begin
               if (res_last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  rank_d  = '0;
               end else begin
                  rank_d = rank_q + RW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides everything above
      if (abort) begin
         state_d   = ST_IDLE;
         stg_v_d   = 1'b0;
         fill_d    = '0;
         idx_cnt_d = '0;
         rank_d    = '0;
         done_d    = 1'b0;
         for (int i = 0; i < L; i++) list_d[i] = '0;
      end

      // Result outputs are loaded from the post-update list so OUT presents them at once
      for (int i = 0; i < L; i++) begin
         if (rank_d == RW'(i)) sel_entry = list_d[i];
      end

      cand_ready_d = (state_d == ST_RUN);
      res_valid_d  = (state_d == ST_OUT);
      busy_d       = (state_d != ST_IDLE);
      res_cand_d   = '0;
      res_score_d  = '0;
      res_idx_d    = '0;
      res_last_d   = 1'b0;
      if (state_d == ST_OUT) begin
         res_cand_d  = sel_entry[CAND_LSB +: K];
         res_score_d = $signed(sel_entry[SCORE_LSB +: SW]);
         res_idx_d   = sel_entry[IDX_LSB +: IDX_WIDTH];
         res_last_d  = (rank_d == (RW'(fill_d) - RW'(1)));
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         u_q          <= '0;
         for (int i = 0; i < L; i++) list_q[i] <= '0;
         fill_q       <= '0;
         idx_cnt_q    <= '0;
         stg_v_q      <= 1'b0;
         stg_score_q  <= '0;
         stg_cand_q   <= '0;
         stg_idx_q    <= '0;
         rank_q       <= '0;
         cand_ready_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_cand_q   <= '0;
         res_score_q  <= '0;
         res_idx_q    <= '0;
         res_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         u_q          <= u_d;
         list_q       <= list_d;
         fill_q       <= fill_d;
         idx_cnt_q    <= idx_cnt_d;
         stg_v_q      <= stg_v_d;
         stg_score_q  <= stg_score_d;
         stg_cand_q   <= stg_cand_d;
         stg_idx_q    <= stg_idx_d;
         rank_q       <= rank_d;
         cand_ready_q <= cand_ready_d;
         res_valid_q  <= res_valid_d;
         res_cand_q   <= res_cand_d;
         res_score_q  <= res_score_d;
         res_idx_q    <= res_idx_d;
         res_last_q   <= res_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.cand_ready = cand_ready_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_cand   = res_cand_q;
   assign bus.res_score  = res_score_q;
   assign bus.res_idx    = res_idx_q;
   assign bus.res_rank   = rank_q;
   assign bus.res_last   = res_last_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
